// File: rtl/srcx1_cfg_pkg.sv
// Shared definitions for the srcx1 configuration scheduler:
//   - FSM state encoding (matches the o_state output encoding)
//   - shadow-bank register addresses
//   - playlist entry word field positions
//   - frames-to-repeat-count helper
package srcx1_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  localparam logic [3:0] ADDR_IQSEL  = 4'd8;
  localparam logic [3:0] ADDR_CELLIQ = 4'd9;
  localparam logic [3:0] ADDR_DSTART = 4'd10;
  localparam logic [3:0] ADDR_DEND   = 4'd11;
  localparam logic [3:0] ADDR_NENT   = 4'd12;
  localparam logic [3:0] ADDR_ERRCLR = 4'd15;

  // Storage is always sized for the largest legal playlist so that the
  // 3-bit entry index addresses it without width juggling.
  localparam int MAX_ENT     = 8;
  localparam int ENT_W       = 12;
  localparam int ENT_VLD_LSB = 0;
  localparam int ENT_VLD_W   = 3;
  localparam int ENT_SEL_BIT = 3;
  localparam int ENT_FRM_LSB = 4;
  localparam int ENT_FRM_W   = 8;

  // A frames field of 0 behaves like 1; the repeat counter holds frames-1.
  function automatic logic [ENT_FRM_W-1:0] frames_to_rep(input logic [ENT_FRM_W-1:0] frames);
    return (frames == '0) ? '0 : frames - 1'b1;
  endfunction

endpackage

// File: rtl/srcx1_frame_wdog.sv
// Frame-head spacing watchdog.
//   clk, asy_rst_n : clock, asynchronous active-low reset
//   i_framn_hd     : frame head pulse
//   i_clr          : clears the sticky error and re-arms on the next head
//   o_hd_err       : sticky error, set by a head at the wrong distance or by
//                    FRAME_CYC cycles passing without a head
module srcx1_frame_wdog #(
  parameter int FRAME_CYC = 4915200
) (
  input  logic clk,
  input  logic asy_rst_n,
  input  logic i_framn_hd,
  input  logic i_clr,
  output logic o_hd_err
);

  localparam int CW = $clog2(FRAME_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(FRAME_CYC - 1);
  localparam logic [CW-1:0] SAT  = CW'(FRAME_CYC);

  logic [CW-1:0] cnt;
  logic          armed;

  // cnt is 0 in the cycle after a head, so the next well-spaced head sees LAST.
  always_ff @(posedge clk or negedge asy_rst_n) begin
    if (!asy_rst_n) begin
      cnt      <= '0;
      armed    <= 1'b0;
      o_hd_err <= 1'b0;
    end else if (i_clr) begin
      cnt      <= '0;
      armed    <= i_framn_hd;
      o_hd_err <= 1'b0;
    end else if (i_framn_hd) begin
      cnt   <= '0;
      armed <= 1'b1;
      if (armed && cnt != LAST) o_hd_err <= 1'b1;
    end else begin
      if (cnt != SAT) cnt <= cnt + 1'b1;
      // Counter is about to reach FRAME_CYC with no head seen.
      if (armed && cnt == LAST) o_hd_err <= 1'b1;
    end
  end

endmodule

// File: rtl/srcx1_cfg_sched_60m.sv
// Frame-synchronous configuration scheduler for the 60M srcx1 interface.
// A CPU-written shadow bank is copied to the live active bank only at a
// frame head following a commit request; a short playlist of test modes is
// stepped through, each entry held for a programmed number of frames.
//   i_cfg_wr/addr/wdata : shadow-bank writes
//   i_commit/o_commit_ack: copy request / one-cycle acknowledge
//   i_run, i_framn_hd    : playlist enable and frame head
//   o_test_sel/o_test_vld: current test mode (0 outside RUN)
//   o_cell_*, o_data_*   : active-bank static configuration
//   o_state, o_entry_idx, o_frame_cnt: status
//   o_hd_err             : sticky frame-spacing error (cleared by addr 15)
module srcx1_cfg_sched_60m
  import srcx1_cfg_pkg::*;
#(
  parameter int NUM_ENT   = 4,
  parameter int FRAME_CYC = 4915200,
  parameter int FCNT_W    = 16
) (
  input  logic              clk,
  input  logic              asy_rst_n,
  input  logic              i_framn_hd,
  input  logic              i_run,
  input  logic              i_cfg_wr,
  input  logic [3:0]        i_cfg_addr,
  input  logic [31:0]       i_cfg_wdata,
  input  logic              i_commit,
  output logic              o_commit_ack,
  output logic              o_test_sel,
  output logic [2:0]        o_test_vld,
  output logic [31:0]       o_cell_iqselcfg,
  output logic [31:0]       o_cell_iq,
  output logic [31:0]       o_data_start,
  output logic [31:0]       o_data_end,
  output logic [1:0]        o_state,
  output logic [2:0]        o_entry_idx,
  output logic [FCNT_W-1:0] o_frame_cnt,
  output logic              o_hd_err
);

  localparam logic [3:0] NUM_ENT_L = 4'(NUM_ENT);

  function automatic logic [3:0] nent_eff(input logic [3:0] raw);
    if (raw == 4'd0)           return 4'd1;
    else if (raw > NUM_ENT_L)  return NUM_ENT_L;
    else                       return raw;
  endfunction

  logic [ENT_W-1:0] sh_ent [MAX_ENT];
  logic [ENT_W-1:0] ac_ent [MAX_ENT];
  logic [31:0] sh_iqsel, sh_celliq, sh_dstart, sh_dend;
  logic [31:0] ac_iqsel, ac_celliq, ac_dstart, ac_dend;
  logic [3:0]  sh_nent, ac_nent;

  logic pending, apply, ack;

  state_t                 state, nxt_state;
  logic [2:0]             idx, nxt_idx, adv_idx;
  logic [ENT_FRM_W-1:0]   rep, nxt_rep;
  logic [FCNT_W-1:0]      fcnt, nxt_fcnt;
  logic [2:0]             tvld, nxt_tvld;
  logic                   tsel, nxt_tsel;
  logic [ENT_W-1:0]       ent0_new, nxt_ent;

  // A commit applies only at a head where the request was already pending.
  assign apply = i_framn_hd & pending;

  // Shadow bank: CPU writes land here unconditionally.
  always_ff @(posedge clk or negedge asy_rst_n) begin
    if (!asy_rst_n) begin
      for (int i = 0; i < MAX_ENT; i++) sh_ent[i] <= '0;
      sh_iqsel  <= '0;
      sh_celliq <= '0;
      sh_dstart <= '0;
      sh_dend   <= '0;
      sh_nent   <= '0;
    end else if (i_cfg_wr) begin
      if (i_cfg_addr < NUM_ENT_L) sh_ent[i_cfg_addr[2:0]] <= i_cfg_wdata[ENT_W-1:0];
      case (i_cfg_addr)
        ADDR_IQSEL:  sh_iqsel  <= i_cfg_wdata;
        ADDR_CELLIQ: sh_celliq <= i_cfg_wdata;
        ADDR_DSTART: sh_dstart <= i_cfg_wdata;
        ADDR_DEND:   sh_dend   <= i_cfg_wdata;
        ADDR_NENT:   sh_nent   <= i_cfg_wdata[3:0];
        default: ;
      endcase
    end
  end

  // Active bank and commit handshake. The copy reads the pre-write shadow
  // when a write coincides with the applying head.
  always_ff @(posedge clk or negedge asy_rst_n) begin
    if (!asy_rst_n) begin
      for (int i = 0; i < MAX_ENT; i++) ac_ent[i] <= '0;
      ac_iqsel  <= '0;
      ac_celliq <= '0;
      ac_dstart <= '0;
      ac_dend   <= '0;
      ac_nent   <= '0;
      pending   <= 1'b0;
      ack       <= 1'b0;
    end else begin
      ack <= apply;
      if (apply) begin
        ac_ent    <= sh_ent;
        ac_iqsel  <= sh_iqsel;
        ac_celliq <= sh_celliq;
        ac_dstart <= sh_dstart;
        ac_dend   <= sh_dend;
        ac_nent   <= sh_nent;
        // A commit arriving with the applying head waits for the next head.
        pending   <= i_commit;
      end else if (i_commit) begin
        pending <= 1'b1;
      end
    end
  end

  // FSM state register (with playlist position and registered test outputs).
  always_ff @(posedge clk or negedge asy_rst_n) begin
    if (!asy_rst_n) begin
      state <= ST_IDLE;
      idx   <= '0;
      rep   <= '0;
      fcnt  <= '0;
      tvld  <= '0;
      tsel  <= 1'b0;
    end else begin
      state <= nxt_state;
      idx   <= nxt_idx;
      rep   <= nxt_rep;
      fcnt  <= nxt_fcnt;
      tvld  <= nxt_tvld;
      tsel  <= nxt_tsel;
    end
  end

  // FSM next-state logic.
  always_comb begin
    nxt_state = state;
    nxt_idx   = idx;
    nxt_rep   = rep;
    nxt_fcnt  = fcnt;
    ent0_new  = apply ? sh_ent[0] : ac_ent[0];
    adv_idx   = (({1'b0, idx} + 4'd1) == nent_eff(ac_nent)) ? 3'd0 : idx + 3'd1;

    // Commit priority: restart the playlist from entry 0 of the new bank.
    if (apply) begin
      nxt_idx = '0;
      nxt_rep = frames_to_rep(ent0_new[ENT_FRM_LSB +: ENT_FRM_W]);
    end

    case (state)
      ST_IDLE: begin
        if (i_run) nxt_state = ST_ARMED;
      end
      ST_ARMED: begin
        if (!i_run) begin
          nxt_state = ST_IDLE;
        end else if (i_framn_hd) begin
          nxt_state = ST_RUN;
          nxt_idx   = '0;
          nxt_rep   = frames_to_rep(ent0_new[ENT_FRM_LSB +: ENT_FRM_W]);
          nxt_fcnt  = fcnt + 1'b1;
        end
      end
      ST_RUN: begin
        if (i_framn_hd) begin
          nxt_fcnt = fcnt + 1'b1;
          if (!apply) begin
            if (rep == '0) begin
              nxt_idx = adv_idx;
              nxt_rep = frames_to_rep(ac_ent[adv_idx][ENT_FRM_LSB +: ENT_FRM_W]);
            end else begin
              nxt_rep = rep - 1'b1;
            end
          end
          if (!i_run) nxt_state = ST_IDLE;
        end
      end
      default: nxt_state = ST_IDLE;
    endcase

    // Test mode is resampled only at heads, so it never changes mid-frame.
    nxt_ent  = apply ? sh_ent[nxt_idx] : ac_ent[nxt_idx];
    nxt_tvld = tvld;
    nxt_tsel = tsel;
    if (i_framn_hd) begin
      if (nxt_state == ST_RUN) begin
        nxt_tvld = nxt_ent[ENT_VLD_LSB +: ENT_VLD_W];
        nxt_tsel = nxt_ent[ENT_SEL_BIT];
      end else begin
        nxt_tvld = '0;
        nxt_tsel = 1'b0;
      end
    end
  end

  // FSM outputs.
  always_comb begin
    o_state         = state;
    o_entry_idx     = idx;
    o_frame_cnt     = fcnt;
    o_test_vld      = tvld;
    o_test_sel      = tsel;
    o_commit_ack    = ack;
    o_cell_iqselcfg = ac_iqsel;
    o_cell_iq       = ac_celliq;
    o_data_start    = ac_dstart;
    o_data_end      = ac_dend;
  end

  srcx1_frame_wdog #(
    .FRAME_CYC (FRAME_CYC)
  ) u_wdog (
    .clk        (clk),
    .asy_rst_n  (asy_rst_n),
    .i_framn_hd (i_framn_hd),
    .i_clr      (i_cfg_wr && (i_cfg_addr == ADDR_ERRCLR)),
    .o_hd_err   (o_hd_err)
  );

endmodule

// File: tb/tb_srcx1_cfg_sched_60m.sv
module tb_srcx1_cfg_sched_60m;

  localparam int FC = 32;

  logic        clk;
  logic        asy_rst_n;
  logic        i_framn_hd;
  logic        i_run;
  logic        i_cfg_wr;
  logic [3:0]  i_cfg_addr;
  logic [31:0] i_cfg_wdata;
  logic        i_commit;
  logic        o_commit_ack;
  logic        o_test_sel;
  logic [2:0]  o_test_vld;
  logic [31:0] o_cell_iqselcfg;
  logic [31:0] o_cell_iq;
  logic [31:0] o_data_start;
  logic [31:0] o_data_end;
  logic [1:0]  o_state;
  logic [2:0]  o_entry_idx;
  logic [15:0] o_frame_cnt;
  logic        o_hd_err;

  int checks = 0;
  int errors = 0;

  srcx1_cfg_sched_60m #(
    .NUM_ENT   (4),
    .FRAME_CYC (FC),
    .FCNT_W    (16)
  ) dut (
    .clk             (clk),
    .asy_rst_n       (asy_rst_n),
    .i_framn_hd      (i_framn_hd),
    .i_run           (i_run),
    .i_cfg_wr        (i_cfg_wr),
    .i_cfg_addr      (i_cfg_addr),
    .i_cfg_wdata     (i_cfg_wdata),
    .i_commit        (i_commit),
    .o_commit_ack    (o_commit_ack),
    .o_test_sel      (o_test_sel),
    .o_test_vld      (o_test_vld),
    .o_cell_iqselcfg (o_cell_iqselcfg),
    .o_cell_iq       (o_cell_iq),
    .o_data_start    (o_data_start),
    .o_data_end      (o_data_end),
    .o_state         (o_state),
    .o_entry_idx     (o_entry_idx),
    .o_frame_cnt     (o_frame_cnt),
    .o_hd_err        (o_hd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running required done");
    $fatal(1);
  end

  typedef struct {
    logic        commit;   // commit pulse in the last cycle of the frame
    logic [2:0]  vld;
    logic        sel;
    logic [2:0]  idx;
    logic [15:0] fcnt;
    logic        ack;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_head();
    i_framn_hd = 1'b1;
    tick();
    i_framn_hd = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    i_cfg_wr    = 1'b1;
    i_cfg_addr  = a;
    i_cfg_wdata = d;
    tick();
    i_cfg_wr    = 1'b0;
  endtask

  initial begin
    // entry words: [2:0] vld, [3] sel, [11:4] frames
    tbl[0] = '{commit: 1'b0, vld: 3'd2, sel: 1'b0, idx: 3'd0, fcnt: 16'd4, ack: 1'b1};
    tbl[1] = '{commit: 1'b0, vld: 3'd3, sel: 1'b0, idx: 3'd1, fcnt: 16'd5, ack: 1'b0};
    tbl[2] = '{commit: 1'b0, vld: 3'd3, sel: 1'b0, idx: 3'd1, fcnt: 16'd6, ack: 1'b0};
    tbl[3] = '{commit: 1'b0, vld: 3'd3, sel: 1'b0, idx: 3'd1, fcnt: 16'd7, ack: 1'b0};
    tbl[4] = '{commit: 1'b0, vld: 3'd2, sel: 1'b0, idx: 3'd0, fcnt: 16'd8, ack: 1'b0};
    tbl[5] = '{commit: 1'b1, vld: 3'd3, sel: 1'b0, idx: 3'd1, fcnt: 16'd9, ack: 1'b0};

    asy_rst_n   = 1'b0;
    i_framn_hd  = 1'b0;
    i_run       = 1'b0;
    i_cfg_wr    = 1'b0;
    i_cfg_addr  = '0;
    i_cfg_wdata = '0;
    i_commit    = 1'b0;
    idle(3);

    chk("rst_state", 32'(o_state), 0);
    chk("rst_vld", 32'(o_test_vld), 0);
    chk("rst_sel", 32'(o_test_sel), 0);
    chk("rst_ack", 32'(o_commit_ack), 0);
    chk("rst_fcnt", 32'(o_frame_cnt), 0);
    chk("rst_dstart", o_data_start, 0);
    chk("rst_err", 32'(o_hd_err), 0);
    asy_rst_n = 1'b1;
    tick();

    // Single-entry playlist, vld 1 sel 1 frames 2.
    wr(4'd0, 32'h29);
    wr(4'd12, 32'd1);
    wr(4'd8, 32'hA5A5_0001);
    i_commit = 1'b1;
    tick();
    i_commit = 1'b0;
    i_run = 1'b1;
    tick();
    chk("armed_state", 32'(o_state), 1);
    chk("armed_vld", 32'(o_test_vld), 0);

    do_head();
    chk("h1_ack", 32'(o_commit_ack), 1);
    chk("h1_vld", 32'(o_test_vld), 1);
    chk("h1_sel", 32'(o_test_sel), 1);
    chk("h1_state", 32'(o_state), 2);
    chk("h1_fcnt", 32'(o_frame_cnt), 1);
    chk("h1_iqsel", o_cell_iqselcfg, 32'hA5A5_0001);
    tick();
    chk("h1_ack_drop", 32'(o_commit_ack), 0);
    idle(FC - 2);
    do_head();
    chk("h2_vld", 32'(o_test_vld), 1);
    chk("h2_idx", 32'(o_entry_idx), 0);
    chk("h2_fcnt", 32'(o_frame_cnt), 2);
    idle(FC - 1);
    do_head();
    chk("h3_idx", 32'(o_entry_idx), 0);
    chk("h3_sel", 32'(o_test_sel), 1);
    // Two-entry playlist: {vld 2, frames 1}, {vld 3, frames 3}.
    wr(4'd0, 32'h12);
    wr(4'd1, 32'h33);
    wr(4'd12, 32'd2);
    i_commit = 1'b1;
    tick();
    i_commit = 1'b0;
    idle(FC - 5);

    for (int r = 0; r < 6; r++) begin
      do_head();
      chk($sformatf("tbl%0d_vld", r), 32'(o_test_vld), 32'(tbl[r].vld));
      chk($sformatf("tbl%0d_sel", r), 32'(o_test_sel), 32'(tbl[r].sel));
      chk($sformatf("tbl%0d_idx", r), 32'(o_entry_idx), 32'(tbl[r].idx));
      chk($sformatf("tbl%0d_fcnt", r), 32'(o_frame_cnt), 32'(tbl[r].fcnt));
      chk($sformatf("tbl%0d_ack", r), 32'(o_commit_ack), 32'(tbl[r].ack));
      chk($sformatf("tbl%0d_err", r), 32'(o_hd_err), 0);
      idle(FC - 2);
      i_commit = tbl[r].commit;
      tick();
      i_commit = 1'b0;
    end

    // Head 10: pending commit applies; same-cycle write and commit.
    i_framn_hd  = 1'b1;
    i_commit    = 1'b1;
    i_cfg_wr    = 1'b1;
    i_cfg_addr  = 4'd10;
    i_cfg_wdata = 32'd100;
    tick();
    i_framn_hd = 1'b0;
    i_commit   = 1'b0;
    i_cfg_wr   = 1'b0;
    chk("h10_ack", 32'(o_commit_ack), 1);
    chk("h10_dstart_old", o_data_start, 0);
    chk("h10_idx_restart", 32'(o_entry_idx), 0);
    chk("h10_vld", 32'(o_test_vld), 2);
    wr(4'd11, 32'd5000);
    idle(FC - 2);
    do_head();
    chk("h11_ack", 32'(o_commit_ack), 1);
    chk("h11_dstart", o_data_start, 100);
    chk("h11_dend", o_data_end, 5000);
    chk("h11_idx", 32'(o_entry_idx), 0);
    tick();
    idle(FC - 2);
    do_head();
    chk("h12_ack", 32'(o_commit_ack), 0);
    chk("h12_vld", 32'(o_test_vld), 3);
    chk("h12_idx", 32'(o_entry_idx), 1);

    // i_run dropped mid-frame: takes effect at the next head only.
    i_run = 1'b0;
    idle(10);
    chk("drop_state_hold", 32'(o_state), 2);
    chk("drop_vld_hold", 32'(o_test_vld), 3);
    idle(FC - 11);
    do_head();
    chk("h13_state", 32'(o_state), 0);
    chk("h13_vld", 32'(o_test_vld), 0);
    chk("h13_sel", 32'(o_test_sel), 0);
    chk("h13_err", 32'(o_hd_err), 0);

    // Head 10 cycles early.
    idle(FC - 11);
    do_head();
    chk("early_err", 32'(o_hd_err), 1);
    idle(5);
    chk("early_err_sticky", 32'(o_hd_err), 1);
    wr(4'd15, 32'd0);
    chk("err_clear", 32'(o_hd_err), 0);

    // Missing head: error at cycle FRAME_CYC after the arming head.
    do_head();
    idle(FC - 1);
    chk("miss_err_before", 32'(o_hd_err), 0);
    tick();
    chk("miss_err_at", 32'(o_hd_err), 1);

    // Asynchronous reset during RUN.
    i_run = 1'b1;
    tick();
    chk("rr_armed", 32'(o_state), 1);
    do_head();
    chk("rr_run", 32'(o_state), 2);
    chk("rr_vld", 32'(o_test_vld), 2);
    idle(3);
    asy_rst_n = 1'b0;
    i_run = 1'b0;
    #2;
    chk("ar_state", 32'(o_state), 0);
    chk("ar_vld", 32'(o_test_vld), 0);
    chk("ar_err", 32'(o_hd_err), 0);
    chk("ar_dstart", o_data_start, 0);
    chk("ar_iqsel", o_cell_iqselcfg, 0);
    chk("ar_fcnt", 32'(o_frame_cnt), 0);
    tick();
    asy_rst_n = 1'b1;
    tick();
    chk("post_state", 32'(o_state), 0);
    chk("post_err", 32'(o_hd_err), 0);
    chk("post_dend", o_data_end, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
